mem_stage: RTL and testbench

- MEM pipeline stage, directly downstream of the EX stage. It consumes the registered ex2mem_t bundle and performs loads and stores on the data-memory port using a req/gnt/rvalid handshake.
- It aligns store data and extracts/extends load data.
- It registers a mem2wb_t bundle for the WB stage.
- It stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_stage_pkg.sv | 65 ++++++
 rtl/lsu_align.sv | 50 +++++
 rtl/mem_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_pkg
//  Purpose  : Shared types for the MEM pipeline stage (EX->MEM and MEM->WB
//             bundles, access sizes, stage FSM states).
//  Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  // Access size; encoding 2'b11 is not named and behaves as a word access
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic       reg_we;
    logic [4:0] rd;
  } wb_pipe_t;

  typedef struct packed {
    logic                  re;
    logic                  we;
    mem_size_e             size;
    logic                  unsigned_ld;
    logic [DATA_WIDTH-1:0] wdata;
  } id2mem_t;

  typedef struct packed {
    id2mem_t               id_stage;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] alu_csr;
    wb_pipe_t              wb_pipeline;
  } ex2mem_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] alu_csr;
    wb_pipe_t              wb_pipeline;
    logic                  misaligned;
  } mem2wb_t;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'b00,
    MEM_REQ    = 2'b01,
    MEM_WAIT_R = 2'b10
  } mem_state_e;

  // Bytes are never misaligned; halves need addr[0]=0, words addr[1:0]=0
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr);
    logic mis;
    case (size)
      MEM_BYTE: mis = 1'b0;
      MEM_HALF: mis = addr[0];
      default:  mis = |addr;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational lane alignment: byte enables and replicated store
//             data, plus shift/truncate/extend of load data.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_align
  import mem_stage_pkg::*;
(
  input  mem_size_e             size_i,
  input  logic [1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  unsigned_ld_i,
  output logic [BE_WIDTH-1:0]   be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_shifted = rdata_i >> {addr_i, 3'b000};

  // Size-dependent enables, store replication and load extension
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = w_shifted;
    case (size_i)
      MEM_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{w_shifted[7] & ~unsigned_ld_i}}, w_shifted[7:0]};
      end
      MEM_HALF: begin
        be_o    = 4'b0011 << addr_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{w_shifted[15] & ~unsigned_ld_i}}, w_shifted[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = w_shifted;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MEM pipeline stage. Issues loads/stores over a req/gnt/rvalid
//             port, aligns data and registers the bundle for WB. Stalls EX
//             while a memory access is outstanding.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  ex2mem_t               mem_pipeline_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [31:0]           data_addr_o,
  output logic                  data_we_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  output mem2wb_t               wb_pipeline_o,
  output logic                  valid_o
);

  mem_state_e            state_q, state_d;
  ex2mem_t               hold_q, hold_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  valid_q, valid_d;
  mem2wb_t               wb_q, wb_d;

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_is_mem;
  logic                  w_mis;
  logic                  w_hold_store;
  mem_size_e             w_size;
  logic [1:0]            w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_unsigned;
  logic [BE_WIDTH-1:0]   w_be;
  logic [DATA_WIDTH-1:0] w_wdata_al;
  logic [DATA_WIDTH-1:0] w_rdata_ext;

  assign w_idle   = (state_q == MEM_IDLE);
  assign w_accept = valid_i & w_idle;
  assign w_is_mem = mem_pipeline_i.id_stage.re | mem_pipeline_i.id_stage.we;
  assign w_mis    = w_is_mem & is_misaligned(mem_pipeline_i.id_stage.size,
                                             mem_pipeline_i.alu_result[1:0]);
  // An op in REQ has re or we set; re&we is a store, so only we=0,re=1 is a load
  assign w_hold_store = hold_q.id_stage.we | ~hold_q.id_stage.re;

  // Aligner sees the incoming op while idle (store setup) and the held op otherwise (load extract)
  assign w_size     = w_idle ? mem_pipeline_i.id_stage.size        : hold_q.id_stage.size;
  assign w_addr     = w_idle ? mem_pipeline_i.alu_result[1:0]      : hold_q.alu_result[1:0];
  assign w_wdata    = w_idle ? mem_pipeline_i.id_stage.wdata       : hold_q.id_stage.wdata;
  assign w_unsigned = w_idle ? mem_pipeline_i.id_stage.unsigned_ld : hold_q.id_stage.unsigned_ld;

  lsu_align u_lsu_align (
    .size_i        (w_size),
    .addr_i        (w_addr),
    .wdata_i       (w_wdata),
    .rdata_i       (data_rdata_i),
    .unsigned_ld_i (w_unsigned),
    .be_o          (w_be),
    .wdata_o       (w_wdata_al),
    .rdata_o       (w_rdata_ext)
  );

  // Next-state, memory-port and writeback bundle computation
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = 1'b0;
    wb_d    = wb_q;
    case (state_q)
      MEM_IDLE: begin
        if (w_accept) begin
          hold_d = mem_pipeline_i;
          if (!w_is_mem || w_mis) begin
            valid_d                = 1'b1;
            wb_d.result            = mem_pipeline_i.alu_result;
            wb_d.alu_csr           = mem_pipeline_i.alu_csr;
            wb_d.wb_pipeline       = mem_pipeline_i.wb_pipeline;
            wb_d.misaligned        = w_mis;
            if (w_mis) begin
              wb_d.wb_pipeline.reg_we = 1'b0;
            end
          end else begin
            state_d = MEM_REQ;
            req_d   = 1'b1;
            we_d    = mem_pipeline_i.id_stage.we;
            be_d    = w_be;
            wdata_d = w_wdata_al;
            addr_d  = {mem_pipeline_i.alu_result[31:2], 2'b00};
          end
        end
      end
      MEM_REQ: begin
        if (data_gnt_i) begin
          req_d = 1'b0;
          if (w_hold_store) begin
            state_d          = MEM_IDLE;
            valid_d          = 1'b1;
            wb_d.result      = hold_q.alu_result;
            wb_d.alu_csr     = hold_q.alu_csr;
            wb_d.wb_pipeline = hold_q.wb_pipeline;
            wb_d.misaligned  = 1'b0;
          end else begin
            state_d = MEM_WAIT_R;
          end
        end
      end
      MEM_WAIT_R: begin
        if (data_rvalid_i) begin
          state_d          = MEM_IDLE;
          valid_d          = 1'b1;
          wb_d.result      = w_rdata_ext;
          wb_d.alu_csr     = hold_q.alu_csr;
          wb_d.wb_pipeline = hold_q.wb_pipeline;
          wb_d.misaligned  = 1'b0;
        end
      end
      default: begin
        state_d = MEM_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= MEM_IDLE;
      hold_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      wb_q    <= wb_d;
    end
  end

  assign ready_o       = w_idle;
  assign data_req_o    = req_q;
  assign data_we_o     = we_q;
  assign data_be_o     = be_q;
  assign data_addr_o   = addr_q;
  assign data_wdata_o  = wdata_q;
  assign valid_o       = valid_q;
  assign wb_pipeline_o = wb_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage with a transaction-level model
//             of expected results, completion cycles and memory requests.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  ex2mem_t     mem_pipeline;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'h0BAD_F00D;
  mem2wb_t     wb_pipeline_o;
  logic        valid_o;

  mem_stage dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .mem_pipeline_i(mem_pipeline),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_addr_o   (data_addr_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_wdata_o  (data_wdata_o),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .wb_pipeline_o (wb_pipeline_o),
    .valid_o       (valid_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic re, we, uns, rwe;
    logic [1:0] size;
    logic [4:0] rd;
    logic [31:0] wdata, addr, rdata;
    int gw, rw;
  } vec_t;

  typedef struct {
    int acc, done, gw;
    logic mem, wb_we, mis, we;
    logic [4:0] rd;
    logic [31:0] result, alu_csr, addr, wdata;
    logic [3:0] be;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  logic chk_en = 1'b0;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] addr,
                                         input logic [1:0] size, input logic uns);
    int n = nbytes(size);
    logic [31:0] v = rdata >> (8 * addr[1:0]);
    logic [31:0] mask;
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (!uns && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [1:0] size);
    int n = nbytes(size);
    if (n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << addr[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wdata, input logic [1:0] size);
    int n = nbytes(size);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic vec_t mkv(input logic re, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata, input logic [31:0] addr,
                               input logic [31:0] rdata, input int gw, input int rw);
    vec_t v;
    v.re = re; v.we = we; v.size = size; v.uns = uns; v.wdata = wdata;
    v.addr = addr; v.rdata = rdata; v.gw = gw; v.rw = rw;
    v.rwe = 1'b1; v.rd = addr[6:2] ^ 5'd7;
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  logic ev, eb, er;
  exp_t ef;
  always @(negedge clk) begin
    if (chk_en) begin
      ev = 1'b0; eb = 1'b0; er = 1'b0;
      if (q.size() > 0) begin
        ef = q[0];
        ev = (cyc == ef.done);
        eb = ef.mem && (cyc > ef.acc) && (cyc < ef.done);
        er = ef.mem && (cyc > ef.acc) && (cyc <= ef.acc + 1 + ef.gw);
      end
      chk("ready_o", {31'b0, ready_o}, {31'b0, !eb});
      chk("valid_o", {31'b0, valid_o}, {31'b0, ev});
      chk("data_req_o", {31'b0, data_req_o}, {31'b0, er});
      if (er && data_req_o) begin
        chk("data_addr_o", data_addr_o, ef.addr);
        chk("data_be_o", {28'b0, data_be_o}, {28'b0, ef.be});
        chk("data_wdata_o", data_wdata_o, ef.wdata);
        chk("data_we_o", {31'b0, data_we_o}, {31'b0, ef.we});
        last_addr = data_addr_o; last_be = data_be_o; last_wdata = data_wdata_o;
      end
      if (ev) begin
        if (valid_o) begin
          chk("wb_result", wb_pipeline_o.result, ef.result);
          chk("wb_alu_csr", wb_pipeline_o.alu_csr, ef.alu_csr);
          chk("wb_reg_we", {31'b0, wb_pipeline_o.wb_pipeline.reg_we}, {31'b0, ef.wb_we});
          chk("wb_rd", {27'b0, wb_pipeline_o.wb_pipeline.rd}, {27'b0, ef.rd});
          chk("wb_misaligned", {31'b0, wb_pipeline_o.misaligned}, {31'b0, ef.mis});
        end
        void'(q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run(input vec_t v);
    exp_t e;
    int   t = 0;
    int   lat;
    while (!ready_o && t < 50) begin @(negedge clk); t++; end
    chk("ready_wait", {31'b0, ready_o}, 32'd1);
    mem_pipeline.id_stage.re          = v.re;
    mem_pipeline.id_stage.we          = v.we;
    mem_pipeline.id_stage.size        = mem_size_e'(v.size);
    mem_pipeline.id_stage.unsigned_ld = v.uns;
    mem_pipeline.id_stage.wdata       = v.wdata;
    mem_pipeline.alu_result           = v.addr;
    mem_pipeline.alu_csr              = v.addr ^ 32'h5A5A_0000;
    mem_pipeline.wb_pipeline.reg_we   = v.rwe;
    mem_pipeline.wb_pipeline.rd       = v.rd;
    valid_i = 1'b1;
    e.acc     = cyc;
    e.gw      = v.gw;
    e.mis     = (v.re | v.we) && ((v.addr % nbytes(v.size)) != 0);
    e.mem     = (v.re | v.we) && !e.mis;
    e.we      = v.we;
    lat       = !e.mem ? 1 : (v.we ? 2 + v.gw : 3 + v.gw + v.rw);
    e.done    = e.acc + lat;
    e.result  = (e.mem && !v.we) ? m_load(v.rdata, v.addr, v.size, v.uns) : v.addr;
    e.alu_csr = v.addr ^ 32'h5A5A_0000;
    e.wb_we   = e.mis ? 1'b0 : v.rwe;
    e.rd      = v.rd;
    e.addr    = {v.addr[31:2], 2'b00};
    e.be      = m_be(v.addr, v.size);
    e.wdata   = m_wdata(v.wdata, v.size);
    q.push_back(e);
    @(negedge clk);
    valid_i = 1'b0;
    mem_pipeline.alu_result     = 32'hDEAD_0000;
    mem_pipeline.id_stage.wdata = 32'h7777_7777;
    if (e.mem) begin
      repeat (v.gw) @(negedge clk);
      data_gnt_i = 1'b1;
      @(negedge clk);
      data_gnt_i = 1'b0;
      if (!v.we) begin
        repeat (v.rw) @(negedge clk);
        data_rvalid_i = 1'b1;
        data_rdata_i  = v.rdata;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0BAD_F00D;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_pipeline = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid_o", {31'b0, valid_o}, 32'd0);
    chk("rst_req", {31'b0, data_req_o}, 32'd0);
    chk("rst_wb", wb_pipeline_o.result, 32'd0);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // non-memory op
    run(mkv(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 32'h0, 0, 0));
    chk("lit_nonmem", wb_pipeline_o.result, 32'h1234_5678);
    // store byte 0xAB at 0x103, two grant wait cycles
    run(mkv(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_00AB, 32'h0000_0103, 32'h0, 2, 0));
    #1;
    chk("lit_sb_be", {28'b0, last_be}, 32'h8);
    chk("lit_sb_wdata", last_wdata, 32'hABAB_ABAB);
    chk("lit_sb_addr", last_addr, 32'h0000_0100);
    // load half signed / unsigned at 0x202, rvalid 3 cycles after gnt
    run(mkv(1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0000_0202, 32'h8001_0000, 0, 2));
    chk("lit_lh", wb_pipeline_o.result, 32'hFFFF_8001);
    run(mkv(1'b1, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_0202, 32'h8001_0000, 0, 2));
    chk("lit_lhu", wb_pipeline_o.result, 32'h0000_8001);
    // misaligned word load
    run(mkv(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0006, 32'h0, 0, 0));
    chk("lit_mis_flag", {31'b0, wb_pipeline_o.misaligned}, 32'd1);
    chk("lit_mis_we", {31'b0, wb_pipeline_o.wb_pipeline.reg_we}, 32'd0);
    // back-to-back loads, immediate gnt and rvalid
    run(mkv(1'b1, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_0041, 32'hDEAD_BEEF, 0, 0));
    run(mkv(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0040, 32'hDEAD_BEEF, 0, 0));
    chk("lit_lw", wb_pipeline_o.result, 32'hDEAD_BEEF);
    // store half at 0x22
    run(mkv(1'b0, 1'b1, 2'b01, 1'b0, 32'h1234_ABCD, 32'h0000_0022, 32'h0, 1, 0));
    #1;
    chk("lit_sh_be", {28'b0, last_be}, 32'hC);
    chk("lit_sh_wdata", last_wdata, 32'hABCD_ABCD);
    // signed byte load, size 11 load, re&we store, misaligned half store
    run(mkv(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0043, 32'h8011_2233, 1, 1));
    chk("lit_lb", wb_pipeline_o.result, 32'hFFFF_FF80);
    run(mkv(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0000_0008, 32'hCAFE_F00D, 0, 1));
    run(mkv(1'b1, 1'b1, 2'b10, 1'b0, 32'h1122_3344, 32'h0000_0014, 32'h0, 0, 0));
    run(mkv(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_5566, 32'h0000_0031, 32'h0, 0, 0));

    // reset while waiting for read data; late rvalid must be ignored
    while (!ready_o) @(negedge clk);
    chk_en = 1'b0;
    mem_pipeline.id_stage.re = 1'b1;
    mem_pipeline.id_stage.we = 1'b0;
    mem_pipeline.id_stage.size = MEM_WORD;
    mem_pipeline.alu_result = 32'h0000_0300;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    @(negedge clk);
    chk("wait_r_ready", {31'b0, ready_o}, 32'd0);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    q.delete();
    chk("midrst_ready", {31'b0, ready_o}, 32'd1);
    chk("midrst_req", {31'b0, data_req_o}, 32'd0);
    chk("midrst_addr", data_addr_o, 32'd0);
    chk("midrst_be", {28'b0, data_be_o}, 32'd0);
    chk("midrst_wdata", data_wdata_o, 32'd0);
    chk("midrst_we", {31'b0, data_we_o}, 32'd0);
    chk("midrst_valid", {31'b0, valid_o}, 32'd0);
    chk("midrst_wb", wb_pipeline_o.result | wb_pipeline_o.alu_csr, 32'd0);
    chk_en = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h1357_9BDF;
    @(negedge clk);
    data_rvalid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_rvalid_ready", {31'b0, ready_o}, 32'd1);
    chk("queue_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
